// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one byte-parallel i2c master among NREQ clients.
// Optional watchdog enabled with `define I2C_ARB_TIMEOUT_EN (adds err and m_rst behaviour).
module i2c_master_arbiter #(
    parameter int NREQ        = 4,
    parameter int BYTES_W     = 3,
    parameter int BYTES_R     = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BYTES_W*8-1:0] req_din,
    input  logic [NREQ*7-1:0]         req_ain,
    input  logic [NREQ-1:0]           req_rnw,
    input  logic [NREQ-1:0]           req_ptr_set,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [BYTES_R*8-1:0]      rdata,
    output logic [BYTES_W*8-1:0]      m_din,
    output logic [6:0]                m_ain,
    output logic                      m_rnw,
    output logic                      m_ptr_set,
    output logic                      m_vin,
    input  logic                      m_busy,
    input  logic [BYTES_R*8-1:0]      m_dout,
    input  logic                      m_vout,
    output logic                      m_rst
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = BYTES_W * 8;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, MRST, DONE} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] pick;
    logic          tmo;
    logic          mrst_end;

    // nearest requester after rr_ptr wins; scanning downward lets the closest one overwrite
    always_comb begin
        pick = rr_ptr;
        for (int i = NREQ; i >= 1; i--)
            if (req[(int'(rr_ptr) + i) % NREQ]) pick = PW'((int'(rr_ptr) + i) % NREQ);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt;
    assign tmo      = (state == WAIT_BUSY || state == RUN) && cnt == CW'(TIMEOUT_CYC - 1);
    assign mrst_end = cnt[0];
    // watchdog: count while the master owns the bus, then hold m_rst for two cycles and flag err
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            m_rst <= 1'b0;
            err   <= 1'b0;
        end else begin
            cnt <= (state == ISSUE || tmo) ? '0 : cnt + 1'b1;
            if (tmo) m_rst <= 1'b1;
            if (state == MRST && mrst_end) begin
                m_rst <= 1'b0;
                err   <= 1'b1;
            end
            if (state == DONE) err <= 1'b0;
        end
    end
`else
    assign tmo      = 1'b0;
    assign mrst_end = 1'b0;
    assign err      = 1'b0;
    assign m_rst    = 1'b0;
`endif

    // transaction sequencer: grant, issue pulse, follow busy, capture read data, signal done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= PW'(NREQ - 1);
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            m_din     <= '0;
            m_ain     <= '0;
            m_rnw     <= 1'b0;
            m_ptr_set <= 1'b0;
            m_vin     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state     <= ISSUE;
                    gnt       <= NREQ'(1) << pick;
                    rr_ptr    <= pick;
                    m_vin     <= 1'b1;
                    m_din     <= req_din[int'(pick) * DW +: DW];
                    m_ain     <= req_ain[int'(pick) * 7 +: 7];
                    m_rnw     <= req_rnw[pick];
                    m_ptr_set <= req_ptr_set[pick];
                end
                ISSUE: begin
                    m_vin <= 1'b0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: state <= tmo ? MRST : m_busy ? RUN : WAIT_BUSY;
                RUN: if (tmo) state <= MRST;
                else begin
                    if (m_vout) rdata <= m_dout;
                    if (!m_busy) begin
                        state <= DONE;
                        done  <= gnt;
                    end
                end
                MRST: if (mrst_end) begin
                    state <= DONE;
                    done  <= gnt;
                end
                default: begin
                    state <= IDLE;
                    done  <= '0;
                    gnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed scoreboard bench for i2c_master_arbiter with a behavioural master.
module tb_i2c_master_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_rnw, req_ptr_set, gnt, done;
    logic [N*24-1:0] req_din;
    logic [N*7-1:0]  req_ain;
    logic            err, m_rnw, m_ptr_set, m_vin, m_busy, m_vout, m_rst;
    logic [15:0]     rdata, m_dout, rd_val;
    logic [23:0]     m_din;
    logic [6:0]      m_ain;
    logic            hang;
    int              busy_len;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              vin_seen, mrst_seen;

    typedef struct {int k; logic [15:0] rd; logic er;} sb_t;
    sb_t q[$];

    i2c_master_arbiter #(.NREQ(N), .BYTES_W(3), .BYTES_R(2), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_din(req_din), .req_ain(req_ain),
        .req_rnw(req_rnw), .req_ptr_set(req_ptr_set), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .m_din(m_din), .m_ain(m_ain), .m_rnw(m_rnw), .m_ptr_set(m_ptr_set),
        .m_vin(m_vin), .m_busy(m_busy), .m_dout(m_dout), .m_vout(m_vout), .m_rst(m_rst)
    );

    always #5 clk = ~clk;

    // behavioural master: busy one cycle after vin, optional read-data pulse, optional hang
    initial begin
        int i;
        m_busy = 1'b0;
        m_vout = 1'b0;
        m_dout = '0;
        forever begin
            @(negedge clk);
            if (m_vin) begin
                @(negedge clk);
                m_busy = 1'b1;
                if (hang) begin
                    while (!m_rst && !rst) @(negedge clk);
                end else begin
                    i = 0;
                    while (i < busy_len && !rst) begin
                        @(negedge clk);
                        i++;
                    end
                    if (m_rnw && !rst) begin
                        m_dout = rd_val;
                        m_vout = 1'b1;
                        @(negedge clk);
                        m_vout = 1'b0;
                    end
                end
                m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_vin();
        int t;
        t = 0;
        while (!m_vin && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("vin_seen", m_vin, 1);
    endtask

    task automatic wait_done(input logic [N-1:0] drop);
        sb_t         e;
        int          t;
        logic        gnt_ok;
        logic [N-1:0] eg;
        t = 0;
        gnt_ok = 1'b1;
        vin_seen = 0;
        mrst_seen = 0;
        eg = N'(1) << q[0].k;
        while (done === '0 && t < 400) begin
            if (gnt !== eg) gnt_ok = 1'b0;
            @(negedge clk);
            t++;
            if (m_vin) vin_seen++;
            if (m_rst) mrst_seen++;
        end
        chk("done_seen", 32'(t < 400), 1);
        e = q.pop_front();
        chk("gnt_hold", gnt_ok, 1);
        chk("done", done, eg);
        chk("gnt_at_done", gnt, eg);
        chk("rdata", rdata, e.rd);
        chk("err", err, e.er);
        req = req & ~drop;
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("gnt_drop", gnt, 0);
    endtask

    initial begin
        int bad;
        hang = 1'b0;
        busy_len = 4;
        rd_val = '0;
        req_rnw = '0;
        req_ptr_set = '0;
        req_din = '0;
        for (int i = 0; i < N; i++) req_ain[i*7 +: 7] = 7'h10 + 7'(i);
        req_ain[6:0] = 7'h3C;
        req_din[23:0] = 24'h00AE80;
        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_vin", m_vin, 0);
        chk("rst_mrst", m_rst, 0);
        chk("rst_ain", m_ain, 0);
        chk("rst_din", m_din, 0);

        // single client 0 write
        req = 4'b0001;
        q.push_back('{0, 16'h0000, 1'b0});
        @(negedge clk);
        chk("t1_vin_lat", m_vin, 1);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_ain", m_ain, 7'h3C);
        chk("t1_din", m_din, 24'h00AE80);
        chk("t1_rnw", m_rnw, 0);
        wait_done(4'b0001);
        chk("t1_single_vin", vin_seen, 0);
        chk("t1_no_mrst", mrst_seen, 0);

        // all requesting: 0,1,2,3,0
        req_ain[6:0] = 7'h10;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) q.push_back('{i % N, 16'h0000, 1'b0});
        for (int i = 0; i < 5; i++) begin
            wait_vin();
            chk("t2_gnt", gnt, 32'(1) << (i % N));
            chk("t2_ain", m_ain, 7'h10 + 7'(i % N));
            wait_done(i == 4 ? 4'b1111 : 4'b0000);
        end

        // client 2 read, then a write keeps the read data
        req_rnw[2] = 1'b1;
        rd_val = 16'hBEEF;
        req = 4'b0100;
        q.push_back('{2, 16'hBEEF, 1'b0});
        wait_vin();
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_rnw", m_rnw, 1);
        wait_done(4'b0100);
        req_rnw[2] = 1'b0;
        rd_val = 16'h1234;
        req = 4'b0100;
        q.push_back('{2, 16'hBEEF, 1'b0});
        wait_vin();
        chk("t3_wr_rnw", m_rnw, 0);
        wait_done(4'b0100);

        // client 1 drops req mid-transaction
        busy_len = 8;
        req = 4'b0010;
        wait_vin();
        chk("t4_gnt", gnt, 4'b0010);
        tick(3);
        req = 4'b0000;
        req_ain[13:7] = 7'h55;
        chk("t4_ain_held", m_ain, 7'h11);
        q.push_back('{1, 16'hBEEF, 1'b0});
        wait_done(4'b0000);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_vin || gnt !== '0) bad++;
        end
        chk("t4_no_regrant", bad, 0);
        req_ain[13:7] = 7'h11;

        // reset during RUN
        req = 4'b0010;
        wait_vin();
        tick(3);
        rst = 1'b1;
        req = '0;
        tick(1);
        rst = 1'b0;
        chk("t5_gnt", gnt, 0);
        chk("t5_vin", m_vin, 0);
        chk("t5_done", done, 0);
        chk("t5_rdata", rdata, 0);
        bad = 0;
        while (m_busy && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        busy_len = 4;
        req = 4'b1111;
        q.push_back('{0, 16'h0000, 1'b0});
        wait_vin();
        chk("t5_rr_restart", gnt, 4'b0001);
        wait_done(4'b1111);

`ifdef I2C_ARB_TIMEOUT_EN
        // hung master: watchdog resets it and the next client is served
        do_reset();
        hang = 1'b1;
        req = 4'b1001;
        q.push_back('{0, 16'h0000, 1'b1});
        wait_vin();
        chk("t6_gnt0", gnt, 4'b0001);
        wait_done(4'b0001);
        chk("t6_mrst_len", mrst_seen, 2);
        hang = 1'b0;
        q.push_back('{3, 16'h0000, 1'b0});
        wait_vin();
        chk("t6_gnt3", gnt, 4'b1000);
        wait_done(4'b1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
